// File: rtl/dac_spi_tx.sv
// Framed SPI write engine for TLV56xx DACs: one or two 16-bit frames per start with programmable SCLK rate.
// Optional two-frame A/B update is built only when DAC_SPI_DUAL_EN is defined.
module dac_spi_tx #(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [3:0]        ctrl,
    input  logic              dual,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              busy,
    output logic              done,
    output logic              cs_n,
    output logic              sclk,
    output logic              sdo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL,
        S_GAP
    } state_e;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    // Control nibble on top, data left-justified into the 12-bit field.
    function automatic logic [15:0] build_frame(input logic [3:0] c, input logic [DATA_W-1:0] d);
        logic [11:0] field;
        field = 12'(d) << (12 - DATA_W);
        return {c, field};
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] frame_q, frame_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        sdo_q, sdo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

`ifdef DAC_SPI_DUAL_EN
    logic        pend_q, pend_d;
    logic [15:0] frame2_q, frame2_d;
`else
    logic        unused_s;
    assign unused_s = ^{dual, data_b};
`endif

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef DAC_SPI_DUAL_EN
        pend_d   = pend_q;
        frame2_d = frame2_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEAD;
                    cnt_d   = DIV_RELOAD;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef DAC_SPI_DUAL_EN
                    if (dual) begin
                        frame_d  = build_frame({1'b0, ctrl[2:1], 1'b1}, data_b);
                        frame2_d = build_frame({1'b1, ctrl[2:1], 1'b0}, data_a);
                        pend_d   = 1'b1;
                    end else begin
                        frame_d  = build_frame(ctrl, data_a);
                        pend_d   = 1'b0;
                    end
`else
                    frame_d = build_frame(ctrl, data_a);
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEAD: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_SHIFT;
                    cnt_d   = DIV_RELOAD;
                    bit_d   = 4'd15;
                    sclk_d  = 1'b1;
                    sdo_d   = frame_q[15];
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SHIFT: begin
                // sdo only moves together with a rising sclk, so it is stable across the high half.
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (sclk_q) begin
                    sclk_d = 1'b0;
                    cnt_d  = DIV_RELOAD;
                end else if (bit_q == 4'd0) begin
                    state_d = S_TRAIL;
                    cnt_d   = DIV_RELOAD;
                end else begin
                    bit_d  = bit_q - 4'd1;
                    sclk_d = 1'b1;
                    sdo_d  = frame_q[bit_q - 4'd1];
                    cnt_d  = DIV_RELOAD;
                end
            end
            S_TRAIL: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_GAP;
                    cnt_d   = DIV_RELOAD;
                    cs_n_d  = 1'b1;
                    sdo_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) begin
`ifdef DAC_SPI_DUAL_EN
                    if (pend_q) begin
                        state_d = S_LEAD;
                        cnt_d   = DIV_RELOAD;
                        cs_n_d  = 1'b0;
                        frame_d = frame2_q;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
`else
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                bit_d   = 4'd0;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                sdo_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 4'd0;
            frame_q <= 16'd0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DAC_SPI_DUAL_EN
            pend_q   <= 1'b0;
            frame2_q <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DAC_SPI_DUAL_EN
            pend_q   <= pend_d;
            frame2_q <= frame2_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign cs_n = cs_n_q;
    assign sclk = sclk_q;
    assign sdo  = sdo_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: three instances (12b/div2, 10b/div2, 12b/div1) sharing data inputs.
module tb_dac_spi_tx;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [2:0]  start_v;
    logic [3:0]  ctrl;
    logic        dual;
    logic [11:0] data_a;
    logic [11:0] data_b;
    logic [2:0]  busy_v, done_v, cs_n_v, sclk_v, sdo_v;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    dac_spi_tx #(.DATA_W(12), .CLK_DIV(2)) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[0]), .ctrl(ctrl), .dual(dual),
        .data_a(data_a), .data_b(data_b), .busy(busy_v[0]), .done(done_v[0]),
        .cs_n(cs_n_v[0]), .sclk(sclk_v[0]), .sdo(sdo_v[0])
    );

    dac_spi_tx #(.DATA_W(10), .CLK_DIV(2)) u_dut10 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[1]), .ctrl(ctrl), .dual(dual),
        .data_a(data_a[9:0]), .data_b(data_b[9:0]), .busy(busy_v[1]), .done(done_v[1]),
        .cs_n(cs_n_v[1]), .sclk(sclk_v[1]), .sdo(sdo_v[1])
    );

    dac_spi_tx #(.DATA_W(12), .CLK_DIV(1)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[2]), .ctrl(ctrl), .dual(dual),
        .data_a(data_a), .data_b(data_b), .busy(busy_v[2]), .done(done_v[2]),
        .cs_n(cs_n_v[2]), .sclk(sclk_v[2]), .sdo(sdo_v[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse start on instance s; returns at the sample one cycle after the accepting edge.
    task automatic launch(input int s, input logic [3:0] c, input logic d,
                          input logic [11:0] a, input logic [11:0] b);
        @(negedge sys_clk);
        ctrl = c; dual = d; data_a = a; data_b = b;
        start_v[s] = 1'b1;
        @(negedge sys_clk);
        start_v[s] = 1'b0;
        check_eq("launch_busy", 32'(busy_v[s]), 32'd1);
        check_eq("launch_cs_n", 32'(cs_n_v[s]), 32'd0);
    endtask

    // Follow a running transfer, capturing sdo on each sclk fall, and check framing/timing.
    task automatic watch(input int s, input string tag, input logic [31:0] exp_word,
                         input int exp_bits, input int exp_busy, input int exp_gap, input int div,
                         input bit noise, input bit chain, input logic [3:0] nc, input logic [11:0] na);
        int i = 0, first_rise = -1, gap = 0, dones = 0, nbits = 0, unstable = 0;
        logic [31:0] cap = 32'd0;
        logic prev = 1'b0, hold = 1'b0;
        while (busy_v[s] && i < exp_busy + 50) begin
            if (sclk_v[s] && !prev) begin
                hold = sdo_v[s];
                if (first_rise < 0) begin
                    first_rise = i;
                    check_eq({tag, "_first_bit"}, 32'(sdo_v[s]), 32'(exp_word[exp_bits-1]));
                end
            end
            if (sclk_v[s] && prev && sdo_v[s] !== hold) unstable++;
            if (!sclk_v[s] && prev) begin
                cap = {cap[30:0], sdo_v[s]};
                nbits++;
            end
            if (cs_n_v[s]) gap++;
            if (done_v[s]) dones++;
            prev = sclk_v[s];
            start_v[s] = noise && (i == 5 || i == 40);
            if (noise && i == 5) begin
                ctrl = ~ctrl; data_a = ~data_a;
            end
            @(negedge sys_clk);
            i++;
        end
        start_v[s] = 1'b0;
        check_eq({tag, "_busy_cycles"}, 32'(i), 32'(exp_busy));
        check_eq({tag, "_done_at_end"}, 32'(done_v[s]), 32'd1);
        check_eq({tag, "_done_early"}, 32'(dones), 32'd0);
        check_eq({tag, "_first_rise"}, 32'(first_rise), 32'(div));
        check_eq({tag, "_cs_gap"}, 32'(gap), 32'(exp_gap));
        check_eq({tag, "_nbits"}, 32'(nbits), 32'(exp_bits));
        check_eq({tag, "_word"}, cap, exp_word);
        check_eq({tag, "_sdo_stable"}, 32'(unstable), 32'd0);
        if (chain) begin
            ctrl = nc; data_a = na; dual = 1'b0;
            start_v[s] = 1'b1;
            @(negedge sys_clk);
            start_v[s] = 1'b0;
            check_eq({tag, "_chain_done"}, 32'(done_v[s]), 32'd0);
            check_eq({tag, "_chain_busy"}, 32'(busy_v[s]), 32'd1);
            check_eq({tag, "_chain_cs_n"}, 32'(cs_n_v[s]), 32'd0);
        end else begin
            @(negedge sys_clk);
            check_eq({tag, "_done_one"}, 32'(done_v[s]), 32'd0);
            check_eq({tag, "_cs_n_idle"}, 32'(cs_n_v[s]), 32'd1);
            check_eq({tag, "_busy_idle"}, 32'(busy_v[s]), 32'd0);
        end
    endtask

    initial begin
        int dn, bz;
        sys_rst_n = 1'b0;
        start_v = 3'b000; ctrl = 4'h0; dual = 1'b0; data_a = 12'h000; data_b = 12'h000;
        repeat (3) @(negedge sys_clk);
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_cs_n", 32'(cs_n_v[k]), 32'd1);
            check_eq("rst_sclk", 32'(sclk_v[k]), 32'd0);
            check_eq("rst_sdo", 32'(sdo_v[k]), 32'd0);
            check_eq("rst_busy_done", 32'({busy_v[k], done_v[k]}), 32'd0);
        end
        sys_rst_n = 1'b1;

        launch(0, 4'hC, 1'b0, 12'hA5C, 12'h000);
        watch(0, "single", 32'h0000CA5C, 16, 70, 2, 2, 1'b0, 1'b0, 4'h0, 12'h000);

        launch(0, 4'h4, 1'b1, 12'h456, 12'h123);
`ifdef DAC_SPI_DUAL_EN
        watch(0, "dual", 32'h5123C456, 32, 140, 4, 2, 1'b0, 1'b0, 4'h0, 12'h000);
`else
        watch(0, "dual_off", 32'h00004456, 16, 70, 2, 2, 1'b0, 1'b0, 4'h0, 12'h000);
`endif

        launch(1, 4'h0, 1'b0, 12'h3FF, 12'h000);
        watch(1, "w10", 32'h00000FFC, 16, 70, 2, 2, 1'b0, 1'b0, 4'h0, 12'h000);

        launch(2, 4'hC, 1'b0, 12'hA5C, 12'h000);
        watch(2, "div1", 32'h0000CA5C, 16, 35, 1, 1, 1'b0, 1'b0, 4'h0, 12'h000);

        launch(0, 4'h3, 1'b0, 12'h5A5, 12'h000);
        watch(0, "busy_drop", 32'h000035A5, 16, 70, 2, 2, 1'b1, 1'b1, 4'hC, 12'h0F0);
        watch(0, "chain", 32'h0000C0F0, 16, 70, 2, 2, 1'b0, 1'b0, 4'h0, 12'h000);

        // Bit 7 of 16'hCADC is 1, so a stuck sdo would show after the abort.
        launch(0, 4'hC, 1'b0, 12'hADC, 12'h000);
        repeat (35) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check_eq("abort_cs_n", 32'(cs_n_v[0]), 32'd1);
        check_eq("abort_sclk", 32'(sclk_v[0]), 32'd0);
        check_eq("abort_sdo", 32'(sdo_v[0]), 32'd0);
        check_eq("abort_busy", 32'(busy_v[0]), 32'd0);
        dn = 0; bz = 0;
        for (int k = 0; k < 80; k++) begin
            if (done_v[0]) dn++;
            if (busy_v[0]) bz++;
            @(negedge sys_clk);
        end
        check_eq("abort_no_done", 32'(dn), 32'd0);
        check_eq("abort_stays_idle", 32'(bz), 32'd0);
        launch(0, 4'hC, 1'b0, 12'hA5C, 12'h000);
        watch(0, "after_abort", 32'h0000CA5C, 16, 70, 2, 2, 1'b0, 1'b0, 4'h0, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
